// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit common-anode 7-segment scan controller
// Round-robin digit scan with leading blank per slot, frame-coherent shadow inputs, blink and blank masks.
module seg_scan_ctrl #(
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 1000,
   parameter int BLINK_CYCLES = 10000000
) (
   input  logic        master_clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [15:0] digit_data,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blank_mask,
   input  logic [3:0]  blink_mask,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [1:0]  scan_idx,
   output logic        frame_tick
);

   localparam int SLOT_W  = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(DIGIT_CYCLES - 1);
   localparam logic [SLOT_W-1:0]  BLANK_END  = SLOT_W'(BLANK_CYCLES);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

   logic [SLOT_W-1:0]  slot_cnt;
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_phase;

   logic [15:0] sh_data;
   logic [3:0]  sh_dp;
   logic [3:0]  sh_blank;
   logic [3:0]  sh_blink;

   logic        frame_start;
   logic        slot_last;
   logic        dark;
   logic [3:0]  cur_nibble;
   logic [3:0]  an_next;
   logic [6:0]  seg_next;
   logic        dp_next;
   logic        tick_next;

   function automatic logic [6:0] font(input logic [3:0] n);
      case (n)
         4'h0:    font = 7'h40;
         4'h1:    font = 7'h79;
         4'h2:    font = 7'h24;
         4'h3:    font = 7'h30;
         4'h4:    font = 7'h19;
         4'h5:    font = 7'h12;
         4'h6:    font = 7'h02;
         4'h7:    font = 7'h78;
         4'h8:    font = 7'h00;
         4'h9:    font = 7'h10;
         4'hA:    font = 7'h08;
         4'hB:    font = 7'h03;
         4'hC:    font = 7'h46;
         4'hD:    font = 7'h21;
         4'hE:    font = 7'h06;
         default: font = 7'h0E;
      endcase
   endfunction

   assign frame_start = enable && (scan_idx == 2'd0) && (slot_cnt == '0);
   assign slot_last   = (slot_cnt == SLOT_LAST);

   always_ff @(posedge master_clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt    <= '0;
         scan_idx    <= 2'd0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (!enable) begin
         slot_cnt    <= '0;
         scan_idx    <= 2'd0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         if (slot_last) begin
            slot_cnt <= '0;
            scan_idx <= scan_idx + 2'd1;
         end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
         end
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
         end
      end
   end

   // Inputs are sampled only at frame start so a frame never mixes old and new data.
   always_ff @(posedge master_clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_data  <= 16'h0000;
         sh_dp    <= 4'h0;
         sh_blank <= 4'h0;
         sh_blink <= 4'h0;
      end else if (frame_start) begin
         sh_data  <= digit_data;
         sh_dp    <= dp_in;
         sh_blank <= blank_mask;
         sh_blink <= blink_mask;
      end
   end

   assign cur_nibble = sh_data[{scan_idx, 2'b00} +: 4];

   // Every slot opens dark, so consecutive anodes are always separated by 4'hF.
   always_comb begin
      dark      = 1'b0;
      an_next   = 4'hF;
      seg_next  = 7'h7F;
      dp_next   = 1'b1;
      tick_next = enable && (scan_idx == 2'd3) && slot_last;
      if (!enable || (slot_cnt < BLANK_END) || sh_blank[scan_idx] ||
          (sh_blink[scan_idx] && blink_phase)) begin
         dark = 1'b1;
      end
      if (!dark) begin
         an_next  = ~(4'b0001 << scan_idx);
         seg_next = font(cur_nibble);
         dp_next  = ~sh_dp[scan_idx];
      end
   end

   always_ff @(posedge master_clk or negedge rst_n) begin
      if (!rst_n) begin
         an         <= 4'hF;
         seg        <= 7'h7F;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         an         <= an_next;
         seg        <= seg_next;
         dp         <= dp_next;
         frame_tick <= tick_next;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

   logic        master_clk;
   logic        rst_n;
   logic        enable;
   logic [15:0] digit_data;
   logic [3:0]  dp_in;
   logic [3:0]  blank_mask;
   logic [3:0]  blink_mask;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [1:0]  scan_idx;
   logic        frame_tick;

   seg_scan_ctrl #(
      .DIGIT_CYCLES(20),
      .BLANK_CYCLES(4),
      .BLINK_CYCLES(100)
   ) dut (
      .master_clk (master_clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .digit_data (digit_data),
      .dp_in      (dp_in),
      .blank_mask (blank_mask),
      .blink_mask (blink_mask),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .scan_idx   (scan_idx),
      .frame_tick (frame_tick)
   );

   initial master_clk = 1'b0;
   always #5 master_clk = ~master_clk;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       ft;
      logic [1:0] idx;
   } exp_t;

   exp_t q[$];
   int n_pass  = 0;
   int n_total = 0;
   int tick_cnt = 0;
   int an3_low  = 0;
   int m_pos    = 0;
   logic [15:0] m_data  = 16'h0;
   logic [3:0]  m_dp    = 4'h0;
   logic [3:0]  m_blank = 4'h0;
   logic [3:0]  m_blink = 4'h0;
   logic [6:0]  font_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   always @(negedge master_clk) begin
      n_total++;
      assert ($countones(~an) <= 1) n_pass++;
      else $error("FAIL one_anode: observed an=%b expected at most one low bit", an);
   end

   // Model state is a single position counter since scanning (re)started.
   task automatic step();
      exp_t e;
      exp_t got;
      int   slot, idx, ph;
      logic drk;
      slot = m_pos % 20;
      idx  = (m_pos / 20) % 4;
      ph   = (m_pos / 100) % 2;
      drk  = !enable || slot < 4 || m_blank[idx] || (m_blink[idx] && ph == 1);
      e.an  = drk ? 4'hF : ~(4'b0001 << idx);
      e.seg = drk ? 7'h7F : font_tbl[m_data[idx*4 +: 4]];
      e.dp  = drk ? 1'b1 : ~m_dp[idx];
      e.ft  = enable && idx == 3 && slot == 19;
      if (enable && (m_pos % 80) == 0) begin
         m_data  = digit_data;
         m_dp    = dp_in;
         m_blank = blank_mask;
         m_blink = blink_mask;
      end
      m_pos = enable ? m_pos + 1 : 0;
      e.idx = 2'((m_pos / 20) % 4);
      q.push_back(e);
      @(posedge master_clk);
      #1;
      got = q.pop_front();
      check("outs", {19'd0, an, seg, dp, frame_tick}, {19'd0, got.an, got.seg, got.dp, got.ft});
      check("scan_idx", {30'd0, scan_idx}, {30'd0, got.idx});
      if (frame_tick) tick_cnt++;
      if (an == 4'b0111) an3_low++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst_n      = 1'b0;
      enable     = 1'b0;
      digit_data = 16'h0;
      dp_in      = 4'h0;
      blank_mask = 4'h0;
      blink_mask = 4'h0;
      #12;
      check("rst_an", {28'd0, an}, 32'hF);
      check("rst_seg", {25'd0, seg}, 32'h7F);
      check("rst_dp", {31'd0, dp}, 32'h1);
      check("rst_idx", {30'd0, scan_idx}, 32'h0);
      check("rst_tick", {31'd0, frame_tick}, 32'h0);
      rst_n = 1'b1;

      // Plain scan of 1A3F, two frames.
      enable     = 1'b1;
      digit_data = 16'h1A3F;
      run(160);
      check("tick_count", tick_cnt, 2);

      // Mid-frame data change in the digit-1 slot is invisible until next frame.
      run(25);
      digit_data = 16'h8888;
      run(55);
      run(80);
      check("seg_8888", {25'd0, seg}, 32'h00);

      // Blink digit 0, permanent blank of digit 3, dp on digit 2.
      blink_mask = 4'b0001;
      blank_mask = 4'b1000;
      dp_in      = 4'b0100;
      an3_low    = 0;
      run(480);
      check("an3_never_low", an3_low, 0);

      // Enable drop mid-slot, then restart with new data.
      while ((m_pos % 20) != 12) step();
      enable = 1'b0;
      run(7);
      digit_data = 16'h0123;
      enable     = 1'b1;
      run(200);

      // Asynchronous reset between edges while a digit is lit.
      while ((m_pos % 80) != 30) step();
      check("pre_rst_lit", {31'd0, (an == 4'hF)}, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_an", {28'd0, an}, 32'hF);
      check("arst_seg", {25'd0, seg}, 32'h7F);
      check("arst_dp", {31'd0, dp}, 32'h1);
      check("arst_idx", {30'd0, scan_idx}, 32'h0);
      m_pos   = 0;
      m_data  = 16'h0;
      m_dp    = 4'h0;
      m_blank = 4'h0;
      m_blink = 4'h0;
      q.delete();
      #20;
      rst_n = 1'b1;
      run(120);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
